// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sign helper for the iterative multiply/divide unit.
package muldiv_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   localparam int NEG_W = 128;
   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
   function automatic logic [NEG_W-1:0] neg_if(input logic [NEG_W-1:0] value, input logic flag);
      return flag ? -value : value;
   endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add multiply step or one restoring-divide step on the accumulator.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               i_is_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_acc
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_part;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   always_comb begin
      w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
      w_part = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
      w_ge   = w_part >= {1'b0, i_b};
      w_diff = WIDTH'(w_part - {1'b0, i_b});
      o_acc  = !i_is_div ? {w_sum, i_acc[WIDTH-1:1]} :
               w_ge      ? {w_diff, i_acc[WIDTH-2:0], 1'b1} :
                           {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU on operand magnitudes, signs fixed up at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic               r_div, r_neg_lo, r_neg_hi, r_dbz;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_dbz_out;
   logic [2*WIDTH-1:0] w_next, w_prod;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;
   logic               w_sgn, w_accept;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .i_is_div(r_div),
      .i_acc   (r_acc),
      .i_b     (r_b),
      .o_acc   (w_next)
   );

   // Divide-by-zero quotient is forced to all ones; the remainder path already yields the original a.
   always_comb begin
      w_sgn    = ~op[0];
      w_abs_a  = (w_sgn && a[WIDTH-1]) ? -a : a;
      w_abs_b  = (w_sgn && b[WIDTH-1]) ? -b : b;
      w_accept = start && !flush && (r_state == IDLE || r_state == DONE);
      w_prod   = (2*WIDTH)'(neg_if(NEG_W'(r_acc), r_neg_lo));
      w_q      = r_dbz ? '1 : WIDTH'(neg_if(NEG_W'(r_acc[WIDTH-1:0]), r_neg_lo));
      w_r      = WIDTH'(neg_if(NEG_W'(r_acc[2*WIDTH-1:WIDTH]), r_neg_hi));
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_b       <= '0;
         r_div     <= 1'b0;
         r_neg_lo  <= 1'b0;
         r_neg_hi  <= 1'b0;
         r_dbz     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_dbz_out <= 1'b0;
      end else if (flush) begin
         r_state <= IDLE;
      end else if (w_accept) begin
         r_state  <= RUN;
         r_cnt    <= CNT_W'(WIDTH);
         r_div    <= op[1];
         r_acc    <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
         r_b      <= op[1] ? w_abs_b : w_abs_a;
         r_neg_lo <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         r_neg_hi <= w_sgn & op[1] & a[WIDTH-1];
         r_dbz    <= op[1] & (b == '0);
      end else if (r_state == RUN) begin
         r_acc <= w_next;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) r_state <= FIXUP;
      end else if (r_state == FIXUP) begin
         r_hi      <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
         r_lo      <= r_div ? w_q : w_prod[WIDTH-1:0];
         r_dbz_out <= r_dbz;
         r_state   <= DONE;
      end else if (r_state == DONE) begin
         r_state <= IDLE;
      end
   end

   assign busy        = (r_state == RUN) || (r_state == FIXUP);
   assign done        = (r_state == DONE);
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz_out;
endmodule
